// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: owns the PC, drives the imem request, sequences redirects/flushes.
// Redirects that land while a fetch is pending are parked until imem accepts, keeping the address stable.
module pc_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             PCSel,
  input  logic [XLEN-1:0]  target_EX,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [XLEN-1:0]  pc_IF,
  output logic [XLEN-1:0]  pc_plus4_IF,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {BOOT, FETCH, REDIR_PEND} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             redirect;
  logic [XLEN-1:0]  tgt_masked;

  assign tgt_masked = {target_EX[XLEN-1:1], 1'b0};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    imem_req    = 1'b0;
    flush_IF_ID = 1'b0;
    flush_ID_EX = 1'b0;
    redirect    = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (PCSel) begin
          redirect    = 1'b1;
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
          if (imem_ready) begin
            pc_d = tgt_masked;
          end else begin
            pend_d  = tgt_masked;
            state_d = REDIR_PEND;
          end
        end else if (!stall_i && imem_ready) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      REDIR_PEND: begin
        // Address stays at the stale PC until imem takes it; that fetch is then flushed.
        imem_req = 1'b1;
        if (PCSel) begin
          redirect    = 1'b1;
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
          if (imem_ready) begin
            pc_d    = tgt_masked;
            state_d = FETCH;
          end else begin
            pend_d = tgt_masked;
          end
        end else if (imem_ready) begin
          flush_IF_ID = 1'b1;
          pc_d        = pend_q;
          state_d     = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
    cnt_d = (redirect && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    mis_d = redirect & target_EX[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_IF        = pc_q;
  assign pc_plus4_IF  = pc_q + XLEN'(4);
  assign misalign_o   = mis_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with hand sequences for counter saturation and mid-redirect reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        PCSel = 1'b0;
  logic [31:0] target_EX = '0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] pc_IF, pc_plus4_IF;
  logic        flush_IF_ID, flush_ID_EX, misalign_o;
  logic [15:0] redirect_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .PCSel(PCSel), .target_EX(target_EX),
    .imem_ready(imem_ready), .imem_req(imem_req), .pc_IF(pc_IF), .pc_plus4_IF(pc_plus4_IF),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .misalign_o(misalign_o),
    .redirect_cnt(redirect_cnt)
  );

  typedef struct {
    logic        stall;
    logic        pcsel;
    logic [31:0] tgt;
    logic        rdy;
    logic        req;
    logic [31:0] pc;
    logic        fif;
    logic        fid;
    logic        mis;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic st, logic ps, logic [31:0] tg, logic rd, logic rq,
                              logic [31:0] p, logic fi, logic fd, logic ms, logic [15:0] c);
    vec_t v;
    v.stall = st; v.pcsel = ps; v.tgt = tg; v.rdy = rd; v.req = rq;
    v.pc = p; v.fif = fi; v.fid = fd; v.mis = ms; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic rq, input logic [31:0] p, input logic fi,
                         input logic fd, input logic ms, input logic [15:0] c);
    chk({tag, ".imem_req"}, 32'(imem_req), 32'(rq));
    chk({tag, ".pc_IF"}, pc_IF, p);
    chk({tag, ".pc_plus4_IF"}, pc_plus4_IF, p + 32'd4);
    chk({tag, ".flush_IF_ID"}, 32'(flush_IF_ID), 32'(fi));
    chk({tag, ".flush_ID_EX"}, 32'(flush_ID_EX), 32'(fd));
    chk({tag, ".misalign_o"}, 32'(misalign_o), 32'(ms));
    chk({tag, ".redirect_cnt"}, 32'(redirect_cnt), 32'(c));
  endtask

  initial begin
    //              st ps tgt           rd   rq pc            fi fd ms cnt
    vecs[0]  = mk(0, 0, 32'h0,        1,   0, 32'h0,        0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,        1,   1, 32'h0,        0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,        1,   1, 32'h4,        0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,        1,   1, 32'h8,        0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 32'h0,        1,   1, 32'hC,        0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 32'h200,      1,   1, 32'h10,       1, 1, 0, 0);
    vecs[6]  = mk(0, 1, 32'h20,       1,   1, 32'h200,      1, 1, 0, 1);
    vecs[7]  = mk(0, 1, 32'h400,      0,   1, 32'h20,       1, 1, 0, 2);
    vecs[8]  = mk(0, 0, 32'h0,        0,   1, 32'h20,       0, 0, 0, 3);
    vecs[9]  = mk(0, 0, 32'h0,        0,   1, 32'h20,       0, 0, 0, 3);
    vecs[10] = mk(0, 0, 32'h0,        1,   1, 32'h20,       1, 0, 0, 3);
    vecs[11] = mk(0, 1, 32'h8,        1,   1, 32'h400,      1, 1, 0, 3);
    vecs[12] = mk(1, 0, 32'h0,        1,   1, 32'h8,        0, 0, 0, 4);
    vecs[13] = mk(1, 0, 32'h0,        1,   1, 32'h8,        0, 0, 0, 4);
    vecs[14] = mk(1, 1, 32'h80,       1,   1, 32'h8,        1, 1, 0, 4);
    vecs[15] = mk(0, 1, 32'h103,      1,   1, 32'h80,       1, 1, 0, 5);
    vecs[16] = mk(0, 0, 32'h0,        1,   1, 32'h102,      0, 0, 1, 6);
    vecs[17] = mk(0, 1, 32'h300,      0,   1, 32'h106,      1, 1, 0, 6);
    vecs[18] = mk(0, 1, 32'h600,      0,   1, 32'h106,      1, 1, 0, 7);
    vecs[19] = mk(0, 0, 32'h0,        0,   1, 32'h106,      0, 0, 0, 8);
    vecs[20] = mk(0, 0, 32'h0,        1,   1, 32'h106,      1, 0, 0, 8);
    vecs[21] = mk(0, 1, 32'h700,      0,   1, 32'h600,      1, 1, 0, 8);
    vecs[22] = mk(0, 1, 32'h7F0,      1,   1, 32'h600,      1, 1, 0, 9);
    vecs[23] = mk(0, 1, 32'hFFFFFFFC, 1,   1, 32'h7F0,      1, 1, 0, 10);
    vecs[24] = mk(0, 0, 32'h0,        1,   1, 32'hFFFFFFFC, 0, 0, 0, 11);
    vecs[25] = mk(0, 0, 32'h0,        0,   1, 32'h0,        0, 0, 0, 11);
    vecs[26] = mk(0, 0, 32'h0,        1,   1, 32'h0,        0, 0, 0, 11);
    vecs[27] = mk(0, 0, 32'h0,        1,   1, 32'h4,        0, 0, 0, 11);

    // Reset state, with PCSel/stall driven to show they have no effect.
    PCSel = 1'b1; stall_i = 1'b1; target_EX = 32'h1234; imem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 0, 32'h0, 0, 0, 0, 16'h0);

    rst = 1'b0;
    for (int i = 0; i < 28; i++) begin
      stall_i = vecs[i].stall; PCSel = vecs[i].pcsel;
      target_EX = vecs[i].tgt; imem_ready = vecs[i].rdy;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].pc, vecs[i].fif,
              vecs[i].fid, vecs[i].mis, vecs[i].cnt);
      @(negedge clk);
    end

    // Saturation: 11 redirects so far, 65524 more reach exactly 0xFFFF.
    stall_i = 1'b0; imem_ready = 1'b1; target_EX = 32'h40;
    for (int i = 0; i < 65524; i++) begin
      PCSel = 1'b1;
      @(negedge clk);
    end
    PCSel = 1'b0;
    #1;
    chk("sat.reach", 32'(redirect_cnt), 32'hFFFF);
    chk("sat.pc", pc_IF, 32'h40);
    PCSel = 1'b1; target_EX = 32'h44;
    @(negedge clk);
    PCSel = 1'b0;
    #1;
    chk("sat.hold", 32'(redirect_cnt), 32'hFFFF);
    chk("sat.pc2", pc_IF, 32'h44);

    // Reset while a redirect to 0x500 is parked.
    @(negedge clk);
    PCSel = 1'b1; target_EX = 32'h500; imem_ready = 1'b0;
    @(negedge clk);
    PCSel = 1'b0;
    #1;
    chk("pend.req", 32'(imem_req), 32'h1);
    chk("pend.pc", pc_IF, 32'h48);
    #1 rst = 1'b1;
    #1;
    chk_all("rst_async", 0, 32'h0, 0, 0, 0, 16'h0);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b1;
    #1;
    chk("rel.boot_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    #1;
    chk("rel.req", 32'(imem_req), 32'h1);
    chk("rel.pc0", pc_IF, 32'h0);
    @(negedge clk);
    #1;
    chk("rel.pc1", pc_IF, 32'h4);
    chk("rel.no_flush", 32'(flush_IF_ID), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
